// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// Module  : tlc_pkg
// Brief   : Shared state, direction and lamp-pattern definitions for the TLC.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tlc_pkg;

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    AR_1   = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    AR_2   = 3'd5,
    PED    = 3'd6,
    FLASH  = 3'd7
  } tlc_state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } tlc_dir_e;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } tlc_lamps_t;

  localparam tlc_lamps_t c_lamps_ns_grn  = 7'b0011000;
  localparam tlc_lamps_t c_lamps_ns_yel  = 7'b0101000;
  localparam tlc_lamps_t c_lamps_all_red = 7'b1001000;
  localparam tlc_lamps_t c_lamps_ew_grn  = 7'b1000010;
  localparam tlc_lamps_t c_lamps_ew_yel  = 7'b1000100;
  localparam tlc_lamps_t c_lamps_ped     = 7'b1001001;

  // Flash shows only the two yellows, both following the flash phase bit.
  function automatic tlc_lamps_t flash_lamps(input logic ph);
    tlc_lamps_t l;
    l           = '0;
    l.ns_yellow = ph;
    l.ew_yellow = ph;
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_phase_timer.sv
// ---------------------------------------------------------------------------
// Module  : tlc_phase_timer
// Brief   : Phase timer: clears on request, counts up, flags the per-state limit.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tlc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == i_limit);

endmodule

`default_nettype wire

// File: rtl/traffic_intersection_controller.sv
// ---------------------------------------------------------------------------
// Module  : traffic_intersection_controller
// Brief   : Two-way intersection Moore FSM with pedestrian phase and flash mode.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_intersection_controller
  import tlc_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 5,
  parameter int FLASH_T  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_req,
  input  logic flash_en,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk
);

  localparam longint c_t_max = longint'(1) << CNT_W;

  generate
    if (GREEN_T < 1 || GREEN_T > c_t_max || YELLOW_T < 1 || YELLOW_T > c_t_max ||
        ALLRED_T < 1 || ALLRED_T > c_t_max || PED_T < 1 || PED_T > c_t_max ||
        FLASH_T < 1 || FLASH_T > c_t_max) begin : g_param_check
      $error("traffic_intersection_controller: phase lengths must lie in 1..2**CNT_W");
    end
  endgenerate

  tlc_state_e       r_state, w_state_nxt;
  tlc_dir_e         r_next_dir, w_next_dir_nxt;
  tlc_lamps_t       r_lamps, w_lamps_nxt;
  logic             r_ped_pend, w_ped_pend_nxt;
  logic             r_flash_ph, w_flash_ph_nxt;
  logic [CNT_W-1:0] w_limit;
  logic             w_done;
  logic             w_ped;
  logic             w_timer_clear;

  always_comb begin
    w_limit = '0;
    case (r_state)
      NS_GRN, EW_GRN: w_limit = CNT_W'(GREEN_T - 1);
      NS_YEL, EW_YEL: w_limit = CNT_W'(YELLOW_T - 1);
      AR_1, AR_2:     w_limit = CNT_W'(ALLRED_T - 1);
      PED:            w_limit = CNT_W'(PED_T - 1);
      FLASH:          w_limit = CNT_W'(FLASH_T - 1);
      default:        w_limit = '0;
    endcase
  end

  // In FLASH the timer wraps every FLASH_T cycles to pace the yellow blink.
  assign w_timer_clear = (w_state_nxt != r_state) || w_done;

  tlc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clear),
    .i_limit (w_limit),
    .o_done  (w_done)
  );

  assign w_ped = r_ped_pend || ped_req;

  always_comb begin
    w_state_nxt    = r_state;
    w_next_dir_nxt = r_next_dir;
    if (flash_en) begin
      w_state_nxt = FLASH;
    end else begin
      case (r_state)
        NS_GRN: if (w_done) w_state_nxt = NS_YEL;
        NS_YEL: if (w_done) w_state_nxt = AR_1;
        AR_1: begin
          if (w_done) begin
            w_state_nxt    = w_ped ? PED : EW_GRN;
            w_next_dir_nxt = DIR_EW;
          end
        end
        EW_GRN: if (w_done) w_state_nxt = EW_YEL;
        EW_YEL: if (w_done) w_state_nxt = AR_2;
        AR_2: begin
          if (w_done) begin
            w_state_nxt    = w_ped ? PED : NS_GRN;
            w_next_dir_nxt = DIR_NS;
          end
        end
        PED:     if (w_done) w_state_nxt = (r_next_dir == DIR_EW) ? EW_GRN : NS_GRN;
        FLASH:   w_state_nxt = AR_2;
        default: w_state_nxt = AR_2;
      endcase
    end
  end

  // Requests arriving during PED re-arm the flag; only PED entry clears it.
  assign w_ped_pend_nxt = (w_state_nxt == PED && r_state != PED) ? 1'b0 : w_ped;

  always_comb begin
    w_flash_ph_nxt = 1'b0;
    if (w_state_nxt == FLASH) begin
      if (r_state != FLASH) begin
        w_flash_ph_nxt = 1'b1;
      end else if (w_done) begin
        w_flash_ph_nxt = ~r_flash_ph;
      end else begin
        w_flash_ph_nxt = r_flash_ph;
      end
    end
  end

  always_comb begin
    w_lamps_nxt = c_lamps_all_red;
    case (w_state_nxt)
      NS_GRN:  w_lamps_nxt = c_lamps_ns_grn;
      NS_YEL:  w_lamps_nxt = c_lamps_ns_yel;
      EW_GRN:  w_lamps_nxt = c_lamps_ew_grn;
      EW_YEL:  w_lamps_nxt = c_lamps_ew_yel;
      PED:     w_lamps_nxt = c_lamps_ped;
      FLASH:   w_lamps_nxt = flash_lamps(w_flash_ph_nxt);
      default: w_lamps_nxt = c_lamps_all_red;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= AR_2;
      r_next_dir <= DIR_NS;
      r_ped_pend <= 1'b0;
      r_flash_ph <= 1'b0;
      r_lamps    <= c_lamps_all_red;
    end else begin
      r_state    <= w_state_nxt;
      r_next_dir <= w_next_dir_nxt;
      r_ped_pend <= w_ped_pend_nxt;
      r_flash_ph <= w_flash_ph_nxt;
      r_lamps    <= w_lamps_nxt;
    end
  end

  assign ns_red    = r_lamps.ns_red;
  assign ns_yellow = r_lamps.ns_yellow;
  assign ns_green  = r_lamps.ns_green;
  assign ew_red    = r_lamps.ew_red;
  assign ew_yellow = r_lamps.ew_yellow;
  assign ew_green  = r_lamps.ew_green;
  assign walk      = r_lamps.walk;

endmodule

`default_nettype wire

// File: doc/traffic_intersection_controller.md
TRAFFIC_INTERSECTION_CONTROLLER -- requirements
Module: traffic_intersection_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the phase timer width in bits.
REQ-002 The block SHALL have parameter GREEN_T, default 8, giving the green phase length in cycles.
REQ-003 The block SHALL have parameter YELLOW_T, default 3, giving the yellow phase length in cycles.
REQ-004 The block SHALL have parameter ALLRED_T, default 2, giving the all-red clearance length in cycles.
REQ-005 The block SHALL have parameter PED_T, default 5, giving the pedestrian walk length in cycles.
REQ-006 The block SHALL have parameter FLASH_T, default 4, giving the flash half-period in cycles.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port ped_req, input, 1 bit: pedestrian request, level or pulse, sampled each cycle.
REQ-010 The block SHALL have port flash_en, input, 1 bit: fault/night mode request.
REQ-011 The block SHALL have ports ns_red, ns_yellow and ns_green, outputs, 1 bit each: north-south lamps.
REQ-012 The block SHALL have ports ew_red, ew_yellow and ew_green, outputs, 1 bit each: east-west lamps.
REQ-013 The block SHALL have port walk, output, 1 bit: pedestrian walk lamp.

Function
REQ-014 The block SHALL be a Moore FSM with states NS_GRN, NS_YEL, AR_1, EW_GRN, EW_YEL, AR_2, PED and FLASH; all lamps SHALL be registered and change on the same edge as the state.
REQ-015 The phase timer SHALL clear to 0 on every state entry, increment once per cycle, and end the phase when it reaches T-1; each phase therefore lasts exactly T cycles.
REQ-016 The normal sequence SHALL be NS_GRN -> NS_YEL -> AR_1 -> EW_GRN -> EW_YEL -> AR_2 -> NS_GRN; one full cycle is 2*(GREEN_T+YELLOW_T+ALLRED_T) cycles.
REQ-017 Lamp decode SHALL be as follows: in a direction's green or yellow state, that direction shows green or yellow and the other shows red; in AR_1, AR_2 and PED, both directions show red; walk SHALL be 1 only in PED.
REQ-018 A ped_req high in any cycle SHALL set the sticky flag ped_pend; ped_pend SHALL clear on entry to PED.
REQ-019 At the end of AR_1 or AR_2, if ped_pend is set or ped_req is high in that cycle, the block SHALL enter PED for PED_T cycles and then go to the green that would otherwise have followed (EW_GRN after AR_1, NS_GRN after AR_2); a 1-bit next_dir register SHALL hold that choice.
REQ-020 A ped_req received during PED SHALL set ped_pend again and be serviced at the next all-red phase, never immediately.
REQ-021 flash_en high SHALL force FLASH on the next edge from any state, overriding both phase expiry and pedestrian service; ped_pend SHALL be retained.
REQ-022 In FLASH, ns_yellow and ew_yellow SHALL toggle together every FLASH_T cycles, starting at 1; all red and green lamps and walk SHALL be 0.
REQ-023 When flash_en falls, the block SHALL go from FLASH to AR_2, giving all-red clearance before NS_GRN, with the timer cleared.
REQ-024 No output combination other than those listed SHALL occur; in particular, both greens, or green together with walk, are illegal.
REQ-025 All T parameters SHALL be at least 1 and at most 2^CNT_W; the block SHALL check this at elaboration.

Reset
REQ-026 While reset is low, the block SHALL asynchronously set state=AR_2, timer=0, ped_pend=0, next_dir=NS, flash phase=0, ns_red=ew_red=1, and all other outputs to 0.
REQ-027 Reset asserted mid-phase SHALL take effect immediately, with no completion of a yellow phase.
REQ-028 After reset is released, the first NS_GRN SHALL begin ALLRED_T cycles after the first active edge.

Structure
REQ-029 The state encoding, the lamp-pattern constants and the direction encoding SHALL live in the shared package tlc_pkg.
REQ-030 The phase timer (clear, increment, terminal compare against a per-state limit) SHALL be a sub-module named tlc_phase_timer; the FSM and lamp decode SHALL stay in the top module.

Verification
REQ-031 With default parameters and no requests, reset is released -> AR_2 for 2 cycles, then NS green 8, NS yellow 3, all-red 2, EW green 8, EW yellow 3, all-red 2; the sequence repeats with a 26-cycle period.
REQ-032 A 1-cycle ped_req pulse during NS_GRN -> AR_1 (2 cycles), then PED with walk=1 for 5 cycles and all red, then EW_GRN.
REQ-033 ped_req high in the final AR_2 cycle -> PED is entered on the next edge, then NS_GRN follows.
REQ-034 flash_en raised mid-EW_GRN -> FLASH on the next edge, with both yellows toggling every 4 cycles; flash_en dropped -> AR_2 for 2 cycles, then NS_GRN.
REQ-035 reset pulsed low mid-NS_YEL (asynchronously, between edges) -> outputs become all-red immediately and ped_pend clears.
REQ-036 A checker SHALL confirm on every cycle, in all scenarios, that both greens are never on together, walk never coincides with any green, and each phase length equals its parameter.
